// File: rtl/seq_det_pkg.sv
// Shared constants for the serial 1011 detector and its match logger.
//   IDX_W_DEF / CNT_W_DEF / DEPTH_DEF / THRESH_DEF : default logger sizing
//   DET_PATTERN : the bit pattern the upstream Mealy detector recognises
package seq_det_pkg;

  localparam int unsigned IDX_W_DEF  = 16;
  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned DEPTH_DEF  = 8;
  localparam int unsigned THRESH_DEF = 4;

  localparam logic [3:0] DET_PATTERN = 4'b1011;

endpackage : seq_det_pkg

// File: rtl/seq_match_logger_fifo.sv
// match_fifo: synchronous show-ahead FIFO with drop-on-full.
//   clk, reset (async, active-low), clear (sync, highest priority)
//   push/din   : write request and data; dropped when full unless a pop
//                is accepted in the same cycle
//   pop        : read request, ignored while empty
//   dout       : registered head entry; holds its last value while empty
//   level      : occupancy 0..DEPTH
//   empty      : level == 0
//   dropped    : pulses for a push that was discarded because the FIFO was full
module match_fifo
  import seq_det_pkg::*;
#(
  parameter int unsigned WIDTH = IDX_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     dropped
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  logic full;
  logic do_push;
  logic do_pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));

  always_comb begin
    do_pop   = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    do_push  = push & (~full | do_pop);
    dropped  = push & full & ~do_pop & ~clear;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    dout_d   = dout_q;

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      dout_d   = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
        level_d = level_q + LW'(1);
      end else if (do_pop && !do_push) begin
        level_d = level_q - LW'(1);
      end
      // Head register: if the new head is the slot written this cycle, take
      // it from din since mem_q does not hold it yet. Hold when going empty.
      if (level_d != '0) begin
        if (do_push && (rd_ptr_d == wr_ptr_q)) begin
          dout_d = din;
        end else begin
          dout_d = mem_q[rd_ptr_d];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      dout_q   <= dout_d;
    end
  end

  // Storage is not reset; only pointers/level define which entries are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout  = dout_q;
  assign level = level_q;

endmodule : match_fifo

// File: rtl/seq_match_logger.sv
// seq_match_logger: timestamps 1011-detector matches and buffers them.
//   clk, reset (async, active-low), clear (sync, same effect as reset)
//   bit_en      : detector consumed a serial bit this cycle (advances index)
//   match       : detector output, qualified by bit_en
//   rd_en       : pop the FIFO head
//   rd_data     : head timestamp (index of the bit that completed the match)
//   rd_valid    : FIFO not empty
//   level       : FIFO occupancy
//   match_count : saturating count of accepted matches (including dropped)
//   overflow    : sticky, a match was lost to a full FIFO
//   irq         : level >= THRESH
module seq_match_logger
  import seq_det_pkg::*;
#(
  parameter int unsigned IDX_W  = IDX_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned THRESH = THRESH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   bit_en,
  input  logic                   match,
  input  logic                   rd_en,
  output logic [IDX_W-1:0]       rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       match_count,
  output logic                   overflow,
  output logic                   irq
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             overflow_q, overflow_d;

  logic push;
  logic fifo_empty;
  logic fifo_dropped;

  assign push = bit_en & match;

  match_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .push    (push),
    .din     (idx_q),
    .pop     (rd_en),
    .dout    (rd_data),
    .level   (level),
    .empty   (fifo_empty),
    .dropped (fifo_dropped)
  );

  always_comb begin
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q;
    if (clear) begin
      idx_d      = '0;
      cnt_d      = '0;
      overflow_d = 1'b0;
    end else begin
      if (bit_en) begin
        idx_d = idx_q + IDX_W'(1);
      end
      if (push && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (fifo_dropped) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q      <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign match_count = cnt_q;
  assign overflow    = overflow_q;
  assign rd_valid    = ~fifo_empty;
  assign irq         = (level >= LW'(THRESH));

endmodule : seq_match_logger
